// File: rtl/regfile_sb.sv
// regfile_sb: 32 x XLEN integer register file with a pending-write scoreboard.
// Two combinational read ports serve decode. One write port takes the
// writeback from MEM/WB. The busy bits track destinations that have issued
// but have not yet been written back, so decode can interlock on RAW hazards.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle
// writeback to the read ports, which also hides the busy bit for that register.
module regfile_sb #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rd_we,
   input  logic [4:0]      rd_addr,
   input  logic [XLEN-1:0] rd_data,
   input  logic            rs1_re,
   input  logic            rs2_re,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            issue_we,
   input  logic [4:0]      issue_addr,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            stall
);

   // x0 has no storage. It reads as zero and is never busy.
   logic [XLEN-1:0] regs_reg [1:31];
   logic [31:1]     busy_reg;

   genvar gi;
   generate
      for (gi = 1; gi < 32; gi++) begin : g_entry
         // Storage for one register. Reset clears it and takes priority over a write.
         always_ff @(posedge clk) begin
            if (rst) begin
               regs_reg[gi] <= '0;
            end else if (rd_we && (rd_addr == 5'(gi))) begin
               regs_reg[gi] <= rd_data;
            end
         end

         // Scoreboard bit for one register. A new issue wins over a writeback
         // on the same edge, because the newer write is still outstanding.
         always_ff @(posedge clk) begin
            if (rst) begin
               busy_reg[gi] <= 1'b0;
            end else if (issue_we && (issue_addr == 5'(gi))) begin
               busy_reg[gi] <= 1'b1;
            end else if (rd_we && (rd_addr == 5'(gi))) begin
               busy_reg[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   logic [XLEN-1:0] rs1_stored, rs2_stored;
   logic            rs1_sb, rs2_sb;
   logic            rs1_wb_hit, rs2_wb_hit;

   // Look up storage and scoreboard for both ports. Address 0 matches no entry,
   // so it falls through to zero and not-busy.
   always_comb begin
      rs1_stored = '0;
      rs2_stored = '0;
      rs1_sb     = 1'b0;
      rs2_sb     = 1'b0;
      for (int i = 1; i < 32; i++) begin
         if (rs1_addr == 5'(i)) begin
            rs1_stored = regs_reg[i];
            rs1_sb     = busy_reg[i];
         end
         if (rs2_addr == 5'(i)) begin
            rs2_stored = regs_reg[i];
            rs2_sb     = busy_reg[i];
         end
      end
   end

   // A writeback this cycle that targets a nonzero source register.
   assign rs1_wb_hit = rd_we && (rd_addr == rs1_addr) && (rs1_addr != 5'd0);
   assign rs2_wb_hit = rd_we && (rd_addr == rs2_addr) && (rs2_addr != 5'd0);

`ifdef REGFILE_BYPASS_EN
   // Write-through path. In-flight writeback data is forwarded, and it also
   // satisfies the pending write for that register.
   always_comb begin
      rs1_data = rs1_wb_hit ? rd_data : rs1_stored;
      rs2_data = rs2_wb_hit ? rd_data : rs2_stored;
      rs1_busy = rs1_wb_hit ? 1'b0 : rs1_sb;
      rs2_busy = rs2_wb_hit ? 1'b0 : rs2_sb;
   end
`else
   // No forwarding. An in-flight writeback keeps its register busy until the
   // write has landed in storage.
   always_comb begin
      rs1_data = rs1_stored;
      rs2_data = rs2_stored;
      rs1_busy = rs1_sb | rs1_wb_hit;
      rs2_busy = rs2_sb | rs2_wb_hit;
   end
`endif

   assign stall = (rs1_re & rs1_busy) | (rs2_re & rs2_busy);

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios followed by randomized traffic, checked
// against a behavioural model. The model is a plain array of register
// values plus a busy flag per register.
// Expected read data and busy flags come from the register-file rules.
module tb_regfile_sb;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            rd_we;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rd_data;
   logic            rs1_re, rs2_re;
   logic [4:0]      rs1_addr, rs2_addr;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            issue_we;
   logic [4:0]      issue_addr;
   logic            rs1_busy, rs2_busy, stall;

   int check_count = 0;
   int error_count = 0;

   // Behavioural model state.
   logic [XLEN-1:0] m_regs [32];
   bit              m_busy [32];

   regfile_sb #(.XLEN(XLEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_we      (rd_we),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rs1_re     (rs1_re),
      .rs2_re     (rs2_re),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .issue_we   (issue_we),
      .issue_addr (issue_addr),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected read data for a port address, given the current inputs.
   function automatic logic [XLEN-1:0] exp_data(input logic [4:0] a);
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (rd_we && rd_addr == a) return rd_data;
`endif
      return m_regs[a];
   endfunction

   // Expected busy flag for a port address, given the current inputs.
   function automatic bit exp_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (rd_we && rd_addr == a) return 1'b0;
      return m_busy[a];
`else
      return m_busy[a] || (rd_we && rd_addr == a);
`endif
   endfunction

   task automatic idle();
      rst = 0; rd_we = 0; rd_addr = 0; rd_data = 0;
      rs1_re = 0; rs2_re = 0; rs1_addr = 0; rs2_addr = 0;
      issue_we = 0; issue_addr = 0;
   endtask

   // Wait for the negative clock edge. Compare all outputs with the model and
   // print one line for this transaction.
   task automatic settle();
      bit e1, e2;
      @(negedge clk);
      e1 = exp_busy(rs1_addr);
      e2 = exp_busy(rs2_addr);
      check("rs1_data", rs1_data, exp_data(rs1_addr));
      check("rs2_data", rs2_data, exp_data(rs2_addr));
      check("rs1_busy", rs1_busy, e1);
      check("rs2_busy", rs2_busy, e2);
      check("stall", stall, (rs1_re & e1) | (rs2_re & e2));
      $display("txn t=%0t rst=%0b we=%0b rd=%0d data=%h iss=%0b ia=%0d rs1=%0d:%h/%0b rs2=%0d:%h/%0b stall=%0b",
               $time, rst, rd_we, rd_addr, rd_data, issue_we, issue_addr,
               rs1_addr, rs1_data, rs1_busy, rs2_addr, rs2_data, rs2_busy, stall);
   endtask

   // Take the rising edge and apply the architectural effect to the model.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (rd_we && rd_addr != 0) begin
            m_regs[rd_addr] = rd_data;
            m_busy[rd_addr] = 1'b0;
         end
         if (issue_we && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic cycle();
      settle();
      tick();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      idle();
      rst = 1;
      tick();
      tick();
      idle();

      // Reset state: every address reads zero and is not busy.
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a); rs2_addr = 5'(31 - a); rs1_re = 1; rs2_re = 1;
         settle();
         check("rst_rs1_data", rs1_data, 0);
         check("rst_stall", stall, 0);
         tick();
      end

      // Preload some registers, then reset while a write and an issue are presented.
      for (int a = 1; a < 6; a++) begin
         idle(); rd_we = 1; rd_addr = 5'(a); rd_data = 32'h1000 + a;
         cycle();
      end
      idle(); issue_we = 1; issue_addr = 5'd2; cycle();
      idle(); rst = 1; rd_we = 1; rd_addr = 5'd4; rd_data = 32'hFFFF_0000;
      issue_we = 1; issue_addr = 5'd6;
      tick();
      for (int a = 1; a < 7; a++) begin
         idle(); rs1_addr = 5'(a); rs1_re = 1; rs2_addr = 5'(a); rs2_re = 1;
         settle();
         check("rst2_data", rs1_data, 0);
         check("rst2_busy", rs1_busy, 0);
         check("rst2_stall", stall, 0);
         tick();
      end

      // x0: writes and issues to x0 are discarded.
      idle(); rd_we = 1; rd_addr = 0; rd_data = 32'hDEADBEEF;
      issue_we = 1; issue_addr = 0; rs1_re = 1; rs1_addr = 0;
      settle();
      check("x0_data_same", rs1_data, 0);
      tick();
      idle(); rs1_re = 1; rs1_addr = 0;
      settle();
      check("x0_data", rs1_data, 0);
      check("x0_busy", rs1_busy, 0);
      tick();

      // Basic write, then read back on both ports.
      idle(); rd_we = 1; rd_addr = 5'd5; rd_data = 32'h12345678; cycle();
      idle(); rs1_re = 1; rs2_re = 1; rs1_addr = 5'd5; rs2_addr = 5'd5;
      settle();
      check("basic_rs1", rs1_data, 32'h12345678);
      check("basic_rs2", rs2_data, 32'h12345678);
      check("basic_stall", stall, 0);
      tick();

      // Scoreboard interlock on x7.
      idle(); issue_we = 1; issue_addr = 5'd7; cycle();
      idle(); rs1_re = 1; rs1_addr = 5'd7;
      settle();
      check("ilock_stall", stall, 1);
      tick();
      rd_we = 1; rd_addr = 5'd7; rd_data = 32'hA5A5A5A5;
      settle();
`ifdef REGFILE_BYPASS_EN
      check("ilock_wb_stall", stall, 0);
      check("ilock_wb_data", rs1_data, 32'hA5A5A5A5);
`else
      check("ilock_wb_stall", stall, 1);
`endif
      tick();
      idle(); rs1_re = 1; rs1_addr = 5'd7;
      settle();
      check("ilock_after_stall", stall, 0);
      check("ilock_after_data", rs1_data, 32'hA5A5A5A5);
      tick();

      // Same-edge set and clear of x9: the set wins.
      idle(); issue_we = 1; issue_addr = 5'd9; rd_we = 1; rd_addr = 5'd9; rd_data = 32'h11;
      cycle();
      idle(); rs1_re = 1; rs1_addr = 5'd9;
      settle();
      check("setclr_busy", rs1_busy, 1);
      check("setclr_stall", stall, 1);
      tick();
      rd_we = 1; rd_addr = 5'd9; rd_data = 32'h99; cycle();
      idle(); rs1_re = 1; rs1_addr = 5'd9;
      settle();
      check("setclr_cleared", rs1_busy, 0);
      check("setclr_data", rs1_data, 32'h99);
      tick();

      // Unused operand: x3 is busy, but rs2 is not read, so decode does not stall.
      idle(); issue_we = 1; issue_addr = 5'd3; cycle();
      idle(); rs2_addr = 5'd3; rs2_re = 0;
      settle();
      check("unused_busy", rs2_busy, 1);
      check("unused_stall", stall, 0);
      tick();

      // Randomized traffic. Addresses are biased to a small set to raise the hit rate.
      for (int n = 0; n < 1500; n++) begin
         idle();
         rst        = ($urandom_range(0, 99) == 0);
         rd_we      = $urandom_range(0, 1);
         rd_addr    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         rd_data    = $urandom;
         issue_we   = $urandom_range(0, 1);
         issue_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         rs1_re     = $urandom_range(0, 1);
         rs2_re     = $urandom_range(0, 1);
         rs1_addr   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         rs2_addr   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
